// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO of fetched words. Flush has priority over push and pop.
// The caller never pops when empty and never pushes into a full FIFO without a pop.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             data_i,
  output fetch_entry_t             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  // Storage is reset so the head output reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word requests to imem, buffers responses, feeds decode.
// Redirects flush the buffer and mark in-flight (and held, ungranted) requests for discard.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fetch_stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  input  logic        instr_ready_i,
  output logic [31:0] fetch_pc_o
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          held_q, held_d;
  logic          held_drop_q, held_drop_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push, pop, gnt, issue_ok;
  logic [CW:0]   used;
  logic [31:0]   redirect_pc;
  fetch_entry_t  push_entry, head;

  assign redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign pop         = !fifo_empty && instr_ready_i && !redirect_i;

  // A same-cycle pop frees a slot, which is what sustains one word per cycle.
  assign used       = {1'b0, outst_q} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign issue_ok   = !fetch_stall_i && !redirect_i && (used < (CW+1)'(BUF_DEPTH));
  assign imem_req_o = !reset && (held_q || issue_ok);
  assign imem_addr_o = held_drop_q ? hold_addr_q : req_pc_q;
  assign gnt        = imem_req_o && imem_gnt_i;

  assign push             = imem_rvalid_i && !redirect_i && (drop_q == '0);
  assign push_entry.instr = imem_err_i ? 32'h0 : imem_rdata_i;
  assign push_entry.fault = imem_err_i;

  always_comb begin
    req_pc_d    = req_pc_q;
    out_pc_d    = out_pc_q;
    hold_addr_d = hold_addr_q;
    held_d      = imem_req_o && !imem_gnt_i;
    held_drop_d = held_drop_q;
    outst_d     = outst_q + CW'(gnt) - CW'(imem_rvalid_i);
    drop_d      = drop_q;
    if (redirect_i) begin
      req_pc_d = redirect_pc;
      out_pc_d = redirect_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d   = outst_d;
      if (imem_req_o && !imem_gnt_i) begin
        held_drop_d = 1'b1;
        hold_addr_d = imem_addr_o;
      end
      if (gnt) held_drop_d = 1'b0;
    end else begin
      if (gnt && held_drop_q) begin
        drop_d      = drop_d + CW'(1);
        held_drop_d = 1'b0;
      end else if (gnt) begin
        req_pc_d = req_pc_q + INSTR_BYTES;
      end
      if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_d - CW'(1);
      if (pop) out_pc_d = out_pc_q + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc_q    <= RESET_PC;
      out_pc_q    <= RESET_PC;
      hold_addr_q <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
      held_q      <= 1'b0;
      held_drop_q <= 1'b0;
    end else begin
      req_pc_q    <= req_pc_d;
      out_pc_q    <= out_pc_d;
      hold_addr_q <= hold_addr_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      held_q      <= held_d;
      held_drop_q <= held_drop_d;
    end
  end

  instr_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fetch_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (push_entry),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full && !pop));

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head.instr;
  assign instr_fault_o = head.fault;
  assign instr_pc_o    = out_pc_q;
  assign fetch_pc_o    = req_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, directed scenarios, random traffic, stream scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_fault_o;
  logic        instr_ready_i;
  logic [31:0] fetch_pc_o;

  instr_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .fetch_stall_i (fetch_stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_err_i    (imem_err_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_fault_o (instr_fault_o),
    .instr_ready_i (instr_ready_i),
    .fetch_pc_o    (fetch_pc_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int          n_vec;
  int          n_miss;
  int          cyc;
  int          n_accept;
  logic        zero_wait, gnt_block, rand_gnt, rand_err, err_en;
  int          lat_min, lat_max;
  logic [31:0] err_addr;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;
  logic [64:0] exp_q[$];
  logic [31:0] fill_pc;
  logic [64:0] mon_e;
  event        sample_ev;

  // Memory contents and error map are pure functions of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (err_en && (a == err_addr)) || (rand_err && (a[6:2] == 5'd19));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference stream: consecutive words from the last restart point.
  task automatic model_fill();
    while (exp_q.size() < 16) begin
      exp_q.push_back({fill_pc, mem_err(fill_pc) ? 32'h0 : mem_word(fill_pc), mem_err(fill_pc)});
      fill_pc = fill_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    fill_pc = {pc[31:2], 2'b00};
    model_fill();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_pre();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    imem_err_i    = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr[0]);
      imem_err_i    = mem_err(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    imem_gnt_i = imem_req_o && !gnt_block && (zero_wait || !rand_gnt || ($urandom_range(0, 3) != 0));
    if (imem_gnt_i) begin
      int due;
      due = cyc + 1 + (zero_wait ? 0 : int'($urandom_range(lat_min, lat_max)));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(imem_addr_o);
      pend_due.push_back(due);
    end
    #1;
    -> sample_ev;
  endtask

  task automatic step_post();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic tick();
    step_pre();
    step_post();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      imem_req_o,    0);
    check({tag, "_valid"},    instr_valid_o, 0);
    check({tag, "_fault"},    instr_fault_o, 0);
    check({tag, "_instr"},    instr_o,       0);
    check({tag, "_fetch_pc"}, fetch_pc_o,    RESET_PC);
    check({tag, "_instr_pc"}, instr_pc_o,    RESET_PC);
  endtask

  task automatic reset_dut();
    reset         = 1'b1;
    redirect_i    = 1'b0;
    fetch_stall_i = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    last_due = 0;
    model_restart(RESET_PC);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    @(sample_ev);
    if (!reset) begin
      if (instr_valid_o && instr_ready_i && !redirect_i) begin
        n_accept++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL stream_empty: got pc=%h with no expected entry", instr_pc_o);
        end else begin
          mon_e = exp_q.pop_front();
          if ({instr_pc_o, instr_o, instr_fault_o} !== mon_e) begin
            n_miss++;
            $display("FAIL stream: got pc=%h instr=%h fault=%b want pc=%h instr=%h fault=%b",
                     instr_pc_o, instr_o, instr_fault_o, mon_e[64:33], mon_e[32:1], mon_e[0]);
          end
        end
        model_fill();
      end
      if (redirect_i) model_restart(redirect_pc_i);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_miss++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int   grants;
    int   nvalid;
    logic found;
    n_vec = 0; n_miss = 0; cyc = 0; n_accept = 0;
    zero_wait = 1'b1; gnt_block = 1'b0; rand_gnt = 1'b0; rand_err = 1'b0; err_en = 1'b0;
    lat_min = 0; lat_max = 0; err_addr = 32'h0; last_due = 0;
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; fetch_stall_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; imem_err_i = 1'b0;
    instr_ready_i = 1'b1;
    @(negedge clk);

    // Zero-wait memory, ready high: back-to-back requests, first valid in cycle 3.
    reset_dut();
    step_pre(); check("t1_req_c1", imem_req_o, 1); check("t1_addr_c1", imem_addr_o, 32'h0);
    check("t1_valid_c1", instr_valid_o, 0); step_post();
    step_pre(); check("t1_addr_c2", imem_addr_o, 32'h4); check("t1_valid_c2", instr_valid_o, 0); step_post();
    step_pre(); check("t1_addr_c3", imem_addr_o, 32'h8); check("t1_valid_c3", instr_valid_o, 1);
    check("t1_pc_c3", instr_pc_o, 32'h0); step_post();
    step_pre(); check("t1_pc_c4", instr_pc_o, 32'h4); step_post();
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      step_pre(); if (instr_valid_o) nvalid++; step_post();
    end
    check("t1_throughput", nvalid, 8);

    // Decode stalled: only BUF_DEPTH grants, then issue stops.
    instr_ready_i = 1'b0;
    reset_dut();
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step_pre(); if (imem_gnt_i) grants++; step_post();
    end
    check("t2_grants", grants, 2);
    step_pre(); check("t2_req_idle", imem_req_o, 0); check("t2_fetch_pc", fetch_pc_o, 32'h8);
    check("t2_head_pc", instr_pc_o, 32'h0); step_post();
    instr_ready_i = 1'b1;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      step_pre(); if (imem_gnt_i) grants++; step_post();
    end
    check("t2_resume_grants", grants, 4);

    // Redirect to 0x1003 with two responses in flight.
    zero_wait = 1'b0; lat_min = 3; lat_max = 3;
    reset_dut();
    tick(); tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_1003;
    step_pre(); check("t3_no_req_redirect", imem_req_o, 0); step_post();
    redirect_i = 1'b0;
    step_pre(); check("t3_fetch_pc", fetch_pc_o, 32'h1000); check("t3_hold_off", imem_req_o, 0); step_post();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_pre();
      if (imem_req_o) begin found = 1'b1; check("t3_addr", imem_addr_o, 32'h1000); end
      step_post();
    end
    check("t3_req_seen", found, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_pre();
      if (instr_valid_o) begin
        found = 1'b1;
        check("t3_first_pc", instr_pc_o, 32'h1000);
        check("t3_first_instr", instr_o, mem_word(32'h1000));
      end
      step_post();
    end
    check("t3_valid_seen", found, 1);

    // Grant withheld three cycles while a redirect to 0x200 arrives.
    zero_wait = 1'b1; gnt_block = 1'b1;
    reset_dut();
    step_pre(); check("t4_req_c1", imem_req_o, 1); check("t4_addr_c1", imem_addr_o, 32'h0); step_post();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step_pre(); check("t4_req_c2", imem_req_o, 1); check("t4_addr_c2", imem_addr_o, 32'h0); step_post();
    redirect_i = 1'b0;
    step_pre(); check("t4_addr_c3", imem_addr_o, 32'h0); check("t4_fetch_pc", fetch_pc_o, 32'h200); step_post();
    gnt_block = 1'b0;
    step_pre(); check("t4_gnt_c4", imem_gnt_i, 1); check("t4_addr_c4", imem_addr_o, 32'h0); step_post();
    step_pre(); check("t4_req_c5", imem_req_o, 1); check("t4_addr_c5", imem_addr_o, 32'h200); step_post();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_pre();
      if (instr_valid_o) begin found = 1'b1; check("t4_first_pc", instr_pc_o, 32'h200); end
      step_post();
    end
    check("t4_valid_seen", found, 1);

    // Bus error on the 0x4 response.
    err_en = 1'b1; err_addr = 32'h4;
    reset_dut();
    tick(); tick();
    step_pre(); check("t5_pc0", instr_pc_o, 32'h0); check("t5_fault0", instr_fault_o, 0); step_post();
    step_pre(); check("t5_pc4", instr_pc_o, 32'h4); check("t5_fault4", instr_fault_o, 1);
    check("t5_instr4", instr_o, 32'h0); step_post();
    step_pre(); check("t5_pc8", instr_pc_o, 32'h8); check("t5_fault8", instr_fault_o, 0);
    check("t5_instr8", instr_o, mem_word(32'h8)); step_post();
    err_en = 1'b0;

    // Asynchronous reset between clock edges mid-burst.
    for (int i = 0; i < 5; i++) tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    pend_addr.delete(); pend_due.delete(); last_due = 0;
    model_restart(RESET_PC);
    @(posedge clk); cyc++; @(negedge clk);
    reset = 1'b0;
    step_pre(); check("t6_no_stale", instr_valid_o, 0); check("t6_addr", imem_addr_o, RESET_PC); step_post();
    tick();
    step_pre(); check("t6_valid", instr_valid_o, 1); check("t6_pc", instr_pc_o, RESET_PC); step_post();

    // Random traffic: grant gaps, variable latency, stalls, back-pressure, redirects, errors.
    zero_wait = 1'b0; rand_gnt = 1'b1; lat_min = 0; lat_max = 2; rand_err = 1'b1;
    reset_dut();
    n_accept = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      fetch_stall_i = ($urandom_range(0, 7) == 0);
      redirect_i    = ($urandom_range(0, 40) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(0, 3)))
                                                  : ($urandom() & 32'h0000_FFFF);
      tick();
    end
    redirect_i = 1'b0; fetch_stall_i = 1'b0;
    check("rand_progress", n_accept > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage. Sits directly upstream of decode and the pipeline control block. Issues word-aligned requests to instruction memory over a request/grant/response handshake and buffers returned words in a small FIFO. Presents them to decode with a valid/ready handshake. Supplies the control block's `fetch_pc_i`, and applies the redirect PC (branch or trap) and fetch stall that control produces.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `BUF_DEPTH`, default `2`: FIFO entries and maximum in-flight requests, power of two, 2 to 8.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `redirect_i` in 1: redirect strobe from control (branch taken or trap entry).
- `redirect_pc_i` in 32: new PC; bits [1:0] are ignored and forced to 0.
- `fetch_stall_i` in 1: blocks new requests; buffering and responses are unaffected.
- `imem_req_o` out 1: request valid.
- `imem_addr_o` out 32: request word address.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response valid.
- `imem_rdata_i` in 32: response data.
- `imem_err_i` in 1: bus error, qualified by `imem_rvalid_i`.
- `instr_valid_o` out 1: FIFO head valid.
- `instr_o` out 32: head instruction.
- `instr_pc_o` out 32: head PC.
- `instr_fault_o` out 1: head carries a fetch access fault.
- `instr_ready_i` in 1: decode consumes the head.
- `fetch_pc_o` out 32: address of the next request to issue (control's `fetch_pc_i`).

## Operation
- State:
  - `req_pc`: next request address.
  - `out_pc`: PC of the FIFO head.
  - `outstanding`: granted requests with no response yet.
  - `drop_cnt`: in-flight responses to discard.
  - FIFO of `{instr, fault}`.
- Issue rule: `imem_req_o` rises only when all of these hold:
  - not `fetch_stall_i`;
  - not `redirect_i`;
  - `outstanding + fifo_count < BUF_DEPTH`, where `outstanding` includes entries counted in `drop_cnt`.
- Request hold: once `imem_req_o` is high without `imem_gnt_i`, the request and address stay stable until granted, even if stall or redirect arrives.
- Grant: `req_pc` increments by 4 (mod 2^32, wraps silently) and `outstanding` increments.
- Response with `drop_cnt > 0`: discarded; `drop_cnt` and `outstanding` each decrement.
- Response with `drop_cnt == 0`: pushed to the FIFO with fault = `imem_err_i`; instr is forced to 0 when faulted. Space is guaranteed by the issue rule, so overflow is impossible. An assertion flags a violation.
- Pop: `instr_valid_o && instr_ready_i` removes the head and increments `out_pc` by 4.
- Redirect:
  - Flushes the FIFO.
  - Sets `req_pc` and `out_pc` to `{redirect_pc_i[31:2], 2'b00}`.
  - Sets `drop_cnt` = `outstanding` minus any response returning that cycle, plus 1 if a held, ungranted request is granted later.
  - A held, ungranted request at redirect time is flagged; its grant adds to `drop_cnt` and does not advance `req_pc`.
- Simultaneous events:
  - Redirect + pop: redirect wins; the pop is ignored.
  - Redirect + response: the response is dropped.
  - Redirect + stall: the PC updates; issue resumes when stall clears.
  - Push + pop on the same cycle: legal at full and at empty. When the FIFO is empty, the push is visible next cycle; there is no bypass.
- Fault entries stall nothing locally. Decode and control raise the trap, then redirect.

## Timing
- Reset values:
  - `imem_req_o`, `instr_valid_o`, `instr_fault_o`: 0.
  - `instr_o`: 0.
  - `fetch_pc_o`, `instr_pc_o`: `RESET_PC`.
  - All counters: 0.
- Reset mid-transaction abandons in-flight responses. Memory is reset by the same `reset`.
- `imem_req_o` may assert in the first cycle after `reset` deasserts.
- Response no earlier than the cycle after grant. `instr_valid_o` asserts the cycle after the accepted `imem_rvalid_i`.
- Minimum redirect-to-valid latency with zero-wait memory: redirect at cycle N, req+gnt at N+1, rvalid at N+2, `instr_valid_o` at N+3.
- Sustained throughput: 1 instruction/cycle with zero-wait memory and `BUF_DEPTH >= 2`.
- `fetch_pc_o` is registered (equals `req_pc`) and updates the cycle after grant or redirect.

## Structure
- `core_package` additions:
  - `fetch_entry_t` packed struct `{logic [31:0] instr; logic fault;}`.
  - Constant `INSTR_BYTES = 4`.
- One sub-module, `fetch_fifo`: a parameterised synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, count.
  - Flush has priority over push and pop.
- Counter widths are `$clog2(BUF_DEPTH)+1`.

## Test plan
- Reset release, zero-wait memory, ready held high: requests at 0x0, 0x4, 0x8 on consecutive cycles; `instr_valid_o` from cycle 3 with `instr_pc_o` 0x0, 0x4, 0x8 and one instruction per cycle.
- Decode ready held low with `BUF_DEPTH=2`: exactly 2 grants, then `imem_req_o` stays 0; `fetch_pc_o` = 0x8. Raising ready drains entries 0x0 and 0x4 and requests resume.
- Redirect to 0x1003 with 2 responses in flight: both in-flight responses are dropped; the next request address is 0x1000; the first valid has `instr_pc_o` = 0x1000.
- Grant withheld for 3 cycles while redirect to 0x200 arrives: address held until grant; that response is dropped; the next request is 0x200.
- `imem_err_i` on the 0x4 response: that entry has `instr_fault_o` = 1 and `instr_o` = 0; adjacent entries are unaffected.
- Async reset asserted mid-burst, between clock edges: all outputs take their reset values immediately; after release, fetch restarts at `RESET_PC` with no stale valid.
